accelerator_write_heads_controller: RTL and testbench

Sequencer for the DNC write-heads datapath. It accepts one write-head job, starts the three scalar units (allocation gate, write gate, write strength) and waits for them. It then streams SIZE_W elements into each vector unit in turn (write key, erase vector, write vector), fetching elements from an upstream buffer, and signals completion. It sits between the DNC top-level controller and the six write-head accelerators.

---
 rtl/accelerator_write_heads_pkg.sv | 26 ++
 rtl/accelerator_write_heads_element_feeder.sv | 67 ++++++
 rtl/accelerator_write_heads_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_accelerator_write_heads_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_write_heads_pkg.sv
// accelerator_write_heads_pkg
// Shared definitions for the DNC write-heads sequencer:
//   - wh_state_e : controller FSM state encoding
//   - PHASE_*    : vector phase encoding, also driven on VECTOR_SEL
//   - DEFAULT_TIMEOUT : default watchdog limit (used only with
//     WRITE_HEADS_CONTROLLER_TIMEOUT_EN defined)
package accelerator_write_heads_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SCALAR_START = 3'd1,
        ST_SCALAR_WAIT  = 3'd2,
        ST_VEC_START    = 3'd3,
        ST_VEC_REQ      = 3'd4,
        ST_VEC_FEED     = 3'd5,
        ST_VEC_WAIT     = 3'd6,
        ST_DONE         = 3'd7
    } wh_state_e;

    localparam logic [1:0] PHASE_KEY    = 2'd0;
    localparam logic [1:0] PHASE_ERASE  = 2'd1;
    localparam logic [1:0] PHASE_VECTOR = 2'd2;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/accelerator_write_heads_element_feeder.sv
// accelerator_write_heads_element_feeder
// Element streaming helper shared by the three vector phases. Holds the element
// index, captures buffer data on request/valid and produces the enable strobe.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clear          clear the element index (phase start)
//   i_req_state      controller is requesting an element
//   i_feed_state     controller is feeding the captured element
//   i_valid, i_data  buffer response
//   i_len            effective vector length
//   o_req            element request
//   o_capture        request accepted this cycle
//   o_enable         element strobe
//   o_last           strobe is for the final element
//   o_index          current element index
//   o_data           captured element
module accelerator_write_heads_element_feeder
    import accelerator_write_heads_pkg::*;
#(
    parameter int DATA_SIZE = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_req_state,
    input  logic                 i_feed_state,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic [DATA_SIZE-1:0] i_len,
    output logic                 o_req,
    output logic                 o_capture,
    output logic                 o_enable,
    output logic                 o_last,
    output logic [DATA_SIZE-1:0] o_index,
    output logic [DATA_SIZE-1:0] o_data
);

    logic [DATA_SIZE-1:0] r_index;
    logic [DATA_SIZE-1:0] r_data;
    logic [DATA_SIZE-1:0] w_index_next;

    assign w_index_next = r_index + DATA_SIZE'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_index <= '0;
            r_data  <= '0;
        end else begin
            if (i_clear) begin
                r_index <= '0;
            end else if (i_feed_state) begin
                r_index <= w_index_next;
            end
            if (o_capture) begin
                r_data <= i_data;
            end
        end
    end

    assign o_req     = i_req_state;
    assign o_capture = i_req_state & i_valid;
    assign o_enable  = i_feed_state;
    assign o_last    = i_feed_state && (w_index_next == i_len);
    assign o_index   = r_index;
    assign o_data    = r_data;

endmodule

// File: rtl/accelerator_write_heads_controller.sv
// accelerator_write_heads_controller
// Sequencer for the DNC write-heads datapath: starts the three scalar units,
// waits for them, then streams min(SIZE_W_IN, W) elements into the write-key,
// erase-vector and write-vector units in turn, then pulses READY.
// Optional watchdog: define WRITE_HEADS_CONTROLLER_TIMEOUT_EN to enable a wait
// counter that aborts the job with an ERROR pulse after TIMEOUT cycles.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   START / READY / BUSY       job handshake; ERROR on watchdog abort
//   SIZE_W_IN, GA_IN, GW_IN, BETA_IN   job parameters captured at START
//   VECTOR_*                   element fetch interface to the upstream buffer
//   <UNIT>_START / <UNIT>_READY        per-unit start pulse and completion
//   scalar / size / element outputs    data towards the six units
module accelerator_write_heads_controller
    import accelerator_write_heads_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int W         = 64
`ifdef WRITE_HEADS_CONTROLLER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    input  logic [DATA_SIZE-1:0] GA_IN,
    input  logic [DATA_SIZE-1:0] GW_IN,
    input  logic [DATA_SIZE-1:0] BETA_IN,
    output logic                 VECTOR_REQ,
    output logic [1:0]           VECTOR_SEL,
    output logic [DATA_SIZE-1:0] VECTOR_INDEX,
    input  logic [DATA_SIZE-1:0] VECTOR_DATA,
    input  logic                 VECTOR_VALID,
    output logic                 ALLOCATION_GATE_START,
    output logic                 WRITE_GATE_START,
    output logic                 WRITE_STRENGTH_START,
    output logic                 WRITE_KEY_START,
    output logic                 ERASE_VECTOR_START,
    output logic                 WRITE_VECTOR_START,
    input  logic                 ALLOCATION_GATE_READY,
    input  logic                 WRITE_GATE_READY,
    input  logic                 WRITE_STRENGTH_READY,
    input  logic                 WRITE_KEY_READY,
    input  logic                 ERASE_VECTOR_READY,
    input  logic                 WRITE_VECTOR_READY,
    output logic [DATA_SIZE-1:0] ALLOCATION_GATE_GA_IN,
    output logic [DATA_SIZE-1:0] WRITE_GATE_GW_IN,
    output logic [DATA_SIZE-1:0] WRITE_STRENGTH_BETA_IN,
    output logic [DATA_SIZE-1:0] WRITE_KEY_SIZE_W_IN,
    output logic [DATA_SIZE-1:0] ERASE_VECTOR_SIZE_W_IN,
    output logic [DATA_SIZE-1:0] WRITE_VECTOR_SIZE_W_IN,
    output logic [DATA_SIZE-1:0] WRITE_KEY_K_IN,
    output logic [DATA_SIZE-1:0] ERASE_VECTOR_E_IN,
    output logic [DATA_SIZE-1:0] WRITE_VECTOR_V_IN,
    output logic                 WRITE_KEY_K_IN_ENABLE,
    output logic                 ERASE_VECTOR_E_IN_ENABLE,
    output logic                 WRITE_VECTOR_V_IN_ENABLE
);

    wh_state_e            r_state;
    wh_state_e            w_state_next;
    logic [1:0]           r_phase;
    logic [1:0]           w_phase_next;
    logic [DATA_SIZE-1:0] r_n;
    logic [DATA_SIZE-1:0] r_ga;
    logic [DATA_SIZE-1:0] r_gw;
    logic [DATA_SIZE-1:0] r_beta;
    // Sticky ready flags: [0]=alloc gate, [1]=write gate, [2]=strength,
    // [3]=key, [4]=erase, [5]=write vector.
    logic [5:0]           r_flags;
    logic [5:0]           w_flags_next;
    logic [5:0]           w_unit_ready;
    logic [2:0]           w_phase_bit;
    logic [DATA_SIZE-1:0] w_n_eff;
    logic                 w_accept;

    logic                 w_req;
    logic                 w_capture;
    logic                 w_feed;
    logic                 w_last;
    logic [DATA_SIZE-1:0] w_index;
    logic [DATA_SIZE-1:0] w_elem_data;

    assign w_unit_ready = {WRITE_VECTOR_READY, ERASE_VECTOR_READY, WRITE_KEY_READY,
                           WRITE_STRENGTH_READY, WRITE_GATE_READY, ALLOCATION_GATE_READY};
    assign w_phase_bit  = 3'd3 + {1'b0, r_phase};
    assign w_n_eff      = (SIZE_W_IN > DATA_SIZE'(W)) ? DATA_SIZE'(W) : SIZE_W_IN;
    assign w_accept     = (r_state == ST_IDLE) && START;

`ifdef WRITE_HEADS_CONTROLLER_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_error;
    logic        w_wait_state;
    logic        w_timeout;

    assign w_wait_state = (r_state == ST_SCALAR_WAIT) || (r_state == ST_VEC_REQ) ||
                          (r_state == ST_VEC_WAIT);
    assign w_timeout    = w_wait_state && (r_wd_cnt == 32'(TIMEOUT - 1));

    // Counter restarts whenever the state changes, including REQ/FEED hops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= w_timeout;
            if (w_state_next != r_state) begin
                r_wd_cnt <= '0;
            end else if (w_wait_state) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
        end
    end

    assign ERROR = r_error;
`else
    assign ERROR = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_flags_next = r_flags | w_unit_ready;
        case (r_state)
            ST_IDLE: begin
                if (START) w_state_next = ST_SCALAR_START;
            end
            ST_SCALAR_START: begin
                // Clear on start, but a ready in this same cycle still counts.
                w_flags_next[2:0] = w_unit_ready[2:0];
                w_state_next      = ST_SCALAR_WAIT;
            end
            ST_SCALAR_WAIT: begin
                if (&r_flags[2:0]) begin
                    if (r_n == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_phase_next = PHASE_KEY;
                        w_state_next = ST_VEC_START;
                    end
                end
            end
            ST_VEC_START: begin
                w_flags_next[w_phase_bit] = w_unit_ready[w_phase_bit];
                w_state_next              = ST_VEC_REQ;
            end
            ST_VEC_REQ: begin
                if (w_capture) w_state_next = ST_VEC_FEED;
            end
            ST_VEC_FEED: begin
                w_state_next = w_last ? ST_VEC_WAIT : ST_VEC_REQ;
            end
            ST_VEC_WAIT: begin
                if (r_flags[w_phase_bit]) begin
                    if (r_phase == PHASE_VECTOR) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_phase_next = r_phase + 2'd1;
                        w_state_next = ST_VEC_START;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
`ifdef WRITE_HEADS_CONTROLLER_TIMEOUT_EN
        if (w_timeout) w_state_next = ST_IDLE;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_phase <= PHASE_KEY;
            r_flags <= '0;
            r_n     <= '0;
            r_ga    <= '0;
            r_gw    <= '0;
            r_beta  <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_flags <= w_flags_next;
            if (w_accept) begin
                r_n    <= w_n_eff;
                r_ga   <= GA_IN;
                r_gw   <= GW_IN;
                r_beta <= BETA_IN;
            end
        end
    end

    accelerator_write_heads_element_feeder #(
        .DATA_SIZE (DATA_SIZE)
    ) u_feeder (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_clear      (r_state == ST_VEC_START),
        .i_req_state  (r_state == ST_VEC_REQ),
        .i_feed_state (r_state == ST_VEC_FEED),
        .i_valid      (VECTOR_VALID),
        .i_data       (VECTOR_DATA),
        .i_len        (r_n),
        .o_req        (w_req),
        .o_capture    (w_capture),
        .o_enable     (w_feed),
        .o_last       (w_last),
        .o_index      (w_index),
        .o_data       (w_elem_data)
    );

    assign BUSY  = (r_state != ST_IDLE);
    assign READY = (r_state == ST_DONE);

    assign ALLOCATION_GATE_START = (r_state == ST_SCALAR_START);
    assign WRITE_GATE_START      = (r_state == ST_SCALAR_START);
    assign WRITE_STRENGTH_START  = (r_state == ST_SCALAR_START);
    assign WRITE_KEY_START       = (r_state == ST_VEC_START) && (r_phase == PHASE_KEY);
    assign ERASE_VECTOR_START    = (r_state == ST_VEC_START) && (r_phase == PHASE_ERASE);
    assign WRITE_VECTOR_START    = (r_state == ST_VEC_START) && (r_phase == PHASE_VECTOR);

    assign VECTOR_REQ   = w_req;
    assign VECTOR_SEL   = w_req ? r_phase : 2'd0;
    assign VECTOR_INDEX = w_req ? w_index : '0;

    assign ALLOCATION_GATE_GA_IN  = r_ga;
    assign WRITE_GATE_GW_IN       = r_gw;
    assign WRITE_STRENGTH_BETA_IN = r_beta;
    assign WRITE_KEY_SIZE_W_IN    = r_n;
    assign ERASE_VECTOR_SIZE_W_IN = r_n;
    assign WRITE_VECTOR_SIZE_W_IN = r_n;

    assign WRITE_KEY_K_IN_ENABLE    = w_feed && (r_phase == PHASE_KEY);
    assign ERASE_VECTOR_E_IN_ENABLE = w_feed && (r_phase == PHASE_ERASE);
    assign WRITE_VECTOR_V_IN_ENABLE = w_feed && (r_phase == PHASE_VECTOR);
    assign WRITE_KEY_K_IN    = WRITE_KEY_K_IN_ENABLE    ? w_elem_data : '0;
    assign ERASE_VECTOR_E_IN = ERASE_VECTOR_E_IN_ENABLE ? w_elem_data : '0;
    assign WRITE_VECTOR_V_IN = WRITE_VECTOR_V_IN_ENABLE ? w_elem_data : '0;

endmodule

// File: tb/tb_accelerator_write_heads_controller.sv
// tb_accelerator_write_heads_controller
// Directed bench for the write-heads sequencer with simple unit and buffer models.
module tb_accelerator_write_heads_controller;

    localparam int DATA_SIZE = 64;
    localparam int W         = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY, BUSY, ERROR;
    logic [63:0] SIZE_W_IN, GA_IN, GW_IN, BETA_IN;
    logic        VECTOR_REQ;
    logic [1:0]  VECTOR_SEL;
    logic [63:0] VECTOR_INDEX, VECTOR_DATA;
    logic        VECTOR_VALID;
    logic        AG_START, WG_START, WS_START, WK_START, EV_START, WV_START;
    logic        AG_READY, WG_READY, WS_READY, WK_READY, EV_READY, WV_READY;
    logic [63:0] AG_GA, WG_GW, WS_BETA, WK_SIZE, EV_SIZE, WV_SIZE;
    logic [63:0] K_IN, E_IN, V_IN;
    logic        K_EN, E_EN, V_EN;

    always #5 CLK = ~CLK;

    accelerator_write_heads_controller #(
        .DATA_SIZE (DATA_SIZE),
        .W         (W)
    ) dut (
        .CLK                      (CLK),
        .RST                      (RST),
        .START                    (START),
        .READY                    (READY),
        .BUSY                     (BUSY),
        .ERROR                    (ERROR),
        .SIZE_W_IN                (SIZE_W_IN),
        .GA_IN                    (GA_IN),
        .GW_IN                    (GW_IN),
        .BETA_IN                  (BETA_IN),
        .VECTOR_REQ               (VECTOR_REQ),
        .VECTOR_SEL               (VECTOR_SEL),
        .VECTOR_INDEX             (VECTOR_INDEX),
        .VECTOR_DATA              (VECTOR_DATA),
        .VECTOR_VALID             (VECTOR_VALID),
        .ALLOCATION_GATE_START    (AG_START),
        .WRITE_GATE_START         (WG_START),
        .WRITE_STRENGTH_START     (WS_START),
        .WRITE_KEY_START          (WK_START),
        .ERASE_VECTOR_START       (EV_START),
        .WRITE_VECTOR_START       (WV_START),
        .ALLOCATION_GATE_READY    (AG_READY),
        .WRITE_GATE_READY         (WG_READY),
        .WRITE_STRENGTH_READY     (WS_READY),
        .WRITE_KEY_READY          (WK_READY),
        .ERASE_VECTOR_READY       (EV_READY),
        .WRITE_VECTOR_READY       (WV_READY),
        .ALLOCATION_GATE_GA_IN    (AG_GA),
        .WRITE_GATE_GW_IN         (WG_GW),
        .WRITE_STRENGTH_BETA_IN   (WS_BETA),
        .WRITE_KEY_SIZE_W_IN      (WK_SIZE),
        .ERASE_VECTOR_SIZE_W_IN   (EV_SIZE),
        .WRITE_VECTOR_SIZE_W_IN   (WV_SIZE),
        .WRITE_KEY_K_IN           (K_IN),
        .ERASE_VECTOR_E_IN        (E_IN),
        .WRITE_VECTOR_V_IN        (V_IN),
        .WRITE_KEY_K_IN_ENABLE    (K_EN),
        .ERASE_VECTOR_E_IN_ENABLE (E_EN),
        .WRITE_VECTOR_V_IN_ENABLE (V_EN)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model knobs
    int   exp_n       = 0;
    int   valid_delay = 0;
    logic early_wg    = 1'b0;
    logic valid_noise = 1'b0;

    // Unit / buffer models: scalar units answer one cycle after START (write gate
    // optionally in the START cycle); vector units answer on their n-th element.
    logic [2:0] sc_rdy_q = 3'b000;
    int wk_cnt = 0, ev_cnt = 0, wv_cnt = 0, req_wait = 0;

    always @(posedge CLK) begin
        sc_rdy_q <= {AG_START, WG_START, WS_START};
        wk_cnt   <= WK_START ? 0 : wk_cnt + int'(K_EN);
        ev_cnt   <= EV_START ? 0 : ev_cnt + int'(E_EN);
        wv_cnt   <= WV_START ? 0 : wv_cnt + int'(V_EN);
        req_wait <= VECTOR_REQ ? req_wait + 1 : 0;
    end

    assign AG_READY = sc_rdy_q[2];
    assign WG_READY = early_wg ? WG_START : sc_rdy_q[1];
    assign WS_READY = sc_rdy_q[0];
    assign WK_READY = K_EN && (wk_cnt == exp_n - 1);
    assign EV_READY = E_EN && (ev_cnt == exp_n - 1);
    assign WV_READY = V_EN && (wv_cnt == exp_n - 1);

    assign VECTOR_VALID = VECTOR_REQ ? (req_wait >= valid_delay) : valid_noise;
    assign VECTOR_DATA  = 64'hD000_0000 | (64'(VECTOR_SEL) << 16) | 64'(VECTOR_INDEX[15:0]);

    // Observation record for the current job
    int          en_ph[$];
    logic [63:0] en_dat[$];
    int          all3_cnt, part_sc_cnt, req_cnt, unstable_cnt, ready_cnt, multi_en_cnt;
    logic        prev_req, prev_valid;
    logic [1:0]  prev_sel;
    logic [63:0] prev_idx;

    task automatic clear_obs();
        en_ph.delete();
        en_dat.delete();
        all3_cnt = 0; part_sc_cnt = 0; req_cnt = 0; unstable_cnt = 0;
        ready_cnt = 0; multi_en_cnt = 0;
        prev_req = 1'b0; prev_valid = 1'b0; prev_sel = 2'd0; prev_idx = '0;
    endtask

    task automatic observe();
        if (AG_START && WG_START && WS_START) all3_cnt++;
        else if (AG_START || WG_START || WS_START) part_sc_cnt++;
        if (VECTOR_REQ) req_cnt++;
        if (prev_req && !prev_valid && VECTOR_REQ &&
            (VECTOR_SEL !== prev_sel || VECTOR_INDEX !== prev_idx)) unstable_cnt++;
        prev_req = VECTOR_REQ; prev_valid = VECTOR_VALID;
        prev_sel = VECTOR_SEL; prev_idx = VECTOR_INDEX;
        if (int'(K_EN) + int'(E_EN) + int'(V_EN) > 1) multi_en_cnt++;
        if (K_EN) begin en_ph.push_back(0); en_dat.push_back(K_IN); end
        if (E_EN) begin en_ph.push_back(1); en_dat.push_back(E_IN); end
        if (V_EN) begin en_ph.push_back(2); en_dat.push_back(V_IN); end
        if (READY) ready_cnt++;
    endtask

    // Called at #1 after an edge with the DUT idle; returns in cycle 1 (SCALAR_START).
    task automatic start_job(input logic [63:0] size, input logic [63:0] ga,
                             input logic [63:0] gw, input logic [63:0] beta);
        clear_obs();
        SIZE_W_IN = size; GA_IN = ga; GW_IN = gw; BETA_IN = beta;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        // Scramble inputs: captured values must hold.
        SIZE_W_IN = 64'd7; GA_IN = 64'hFFFF; GW_IN = 64'hEEEE; BETA_IN = 64'hDDDD;
        observe();
    endtask

    // Runs until READY or budget; lat = cycle index of READY (START edge = 0), -1 on expiry.
    // Holds START high for 3 cycles from cycle busy_at (if >0) to probe busy-ignore.
    task automatic run_to_ready(input int budget, input int busy_at, output int lat);
        int cyc;
        cyc = 1;
        lat = READY ? 1 : -1;
        while (lat < 0 && cyc < budget) begin
            if (cyc == busy_at) START = 1'b1;
            if (cyc == busy_at + 3) START = 1'b0;
            @(posedge CLK); #1;
            cyc++;
            observe();
            if (READY) lat = cyc;
        end
        START = 1'b0;
        @(posedge CLK); #1;
        observe();
    endtask

    task automatic check_stream(input string name, input int n);
        logic [63:0] want;
        n_vec++;
        if (en_ph.size() != 3 * n) begin
            n_bad++;
            $display("FAIL %s enable count: got %0d want %0d", name, en_ph.size(), 3 * n);
        end else begin
            for (int k = 0; k < 3 * n; k++) begin
                want = 64'hD000_0000 | (64'(k / n) << 16) | 64'(k % n);
                n_vec++;
                if (en_ph[k] != k / n || en_dat[k] !== want) begin
                    n_bad++;
                    $display("FAIL %s element %0d: got phase %0d data %h want phase %0d data %h",
                             name, k, en_ph[k], en_dat[k], k / n, want);
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0;
        SIZE_W_IN = '0; GA_IN = '0; GW_IN = '0; BETA_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if ({BUSY, READY, ERROR, VECTOR_REQ, AG_START, WG_START, WS_START,
             WK_START, EV_START, WV_START, K_EN, E_EN, V_EN} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {BUSY, READY, ERROR, VECTOR_REQ});
        end
        n_vec++;
        if ((AG_GA | WG_GW | WS_BETA | WK_SIZE | EV_SIZE | WV_SIZE |
             K_IN | E_IN | V_IN | VECTOR_INDEX) !== 64'd0 || VECTOR_SEL !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_data: got nonzero data outputs want 0");
        end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_scalar_only();
        int lat;
        exp_n = 0; valid_delay = 0; early_wg = 1'b0; valid_noise = 1'b0;
        start_job(64'd0, 64'd11, 64'd22, 64'd33);
        run_to_ready(200, 0, lat);
        n_vec++;
        if (lat != 4) begin
            n_bad++; $display("FAIL scalar_latency: got %0d want 4", lat);
        end
        n_vec++;
        if (all3_cnt != 1 || part_sc_cnt != 0) begin
            n_bad++;
            $display("FAIL scalar_starts: got together=%0d partial=%0d want 1/0",
                     all3_cnt, part_sc_cnt);
        end
        n_vec++;
        if (req_cnt != 0 || en_ph.size() != 0) begin
            n_bad++;
            $display("FAIL scalar_no_vec: got req=%0d en=%0d want 0/0", req_cnt, en_ph.size());
        end
        n_vec++;
        if (ready_cnt != 1 || BUSY !== 1'b0) begin
            n_bad++; $display("FAIL scalar_ready: got pulses=%0d busy=%b want 1/0", ready_cnt, BUSY);
        end
        n_vec++;
        if (AG_GA !== 64'd11 || WG_GW !== 64'd22 || WS_BETA !== 64'd33) begin
            n_bad++;
            $display("FAIL scalar_capture: got %0d/%0d/%0d want 11/22/33", AG_GA, WG_GW, WS_BETA);
        end
    endtask

    task automatic test_normal();
        int lat;
        exp_n = 4; valid_delay = 0; early_wg = 1'b0; valid_noise = 1'b0;
        start_job(64'd4, 64'd1, 64'd2, 64'd3);
        run_to_ready(500, 0, lat);
        n_vec++;
        if (lat != 34) begin
            n_bad++; $display("FAIL normal_latency: got %0d want 34", lat);
        end
        check_stream("normal", 4);
        n_vec++;
        if (WK_SIZE !== 64'd4 || EV_SIZE !== 64'd4 || WV_SIZE !== 64'd4) begin
            n_bad++; $display("FAIL normal_size: got %0d want 4", WK_SIZE);
        end
        n_vec++;
        if (ready_cnt != 1 || multi_en_cnt != 0) begin
            n_bad++;
            $display("FAIL normal_pulses: got ready=%0d multi=%0d want 1/0", ready_cnt, multi_en_cnt);
        end
    endtask

    task automatic test_clamp();
        int lat;
        exp_n = 64; valid_delay = 0; early_wg = 1'b0; valid_noise = 1'b0;
        start_job(64'd100, 64'd5, 64'd6, 64'd7);
        run_to_ready(2000, 0, lat);
        n_vec++;
        if (lat != 394) begin
            n_bad++; $display("FAIL clamp_latency: got %0d want 394", lat);
        end
        n_vec++;
        if (WK_SIZE !== 64'd64 || EV_SIZE !== 64'd64 || WV_SIZE !== 64'd64) begin
            n_bad++; $display("FAIL clamp_size: got %0d want 64", WK_SIZE);
        end
        check_stream("clamp", 64);
    endtask

    task automatic test_backpressure();
        int lat;
        exp_n = 4; valid_delay = 3; early_wg = 1'b1; valid_noise = 1'b1;
        start_job(64'd4, 64'd8, 64'd9, 64'd10);
        run_to_ready(1000, 10, lat);
        n_vec++;
        if (lat != 70) begin
            n_bad++; $display("FAIL bp_latency: got %0d want 70", lat);
        end
        n_vec++;
        if (unstable_cnt != 0) begin
            n_bad++; $display("FAIL bp_req_stable: got %0d changes want 0", unstable_cnt);
        end
        n_vec++;
        if (req_cnt != 48) begin
            n_bad++; $display("FAIL bp_req_cycles: got %0d want 48", req_cnt);
        end
        check_stream("bp", 4);
        repeat (3) begin @(posedge CLK); #1; observe(); end
        n_vec++;
        if (ready_cnt != 1 || BUSY !== 1'b0 || all3_cnt != 1) begin
            n_bad++;
            $display("FAIL bp_busy_start: got ready=%0d busy=%b starts=%0d want 1/0/1",
                     ready_cnt, BUSY, all3_cnt);
        end
        early_wg = 1'b0; valid_noise = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        exp_n = 4; valid_delay = 0; early_wg = 1'b0; valid_noise = 1'b0;
        start_job(64'd4, 64'd1, 64'd1, 64'd1);
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (VECTOR_REQ && VECTOR_SEL == 2'd1) seen = 1;
            else begin @(posedge CLK); #1; end
        end
        n_vec++;
        if (seen == 0) begin
            n_bad++; $display("FAIL rst_mid_reach: got no erase request want one");
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        n_vec++;
        if ({BUSY, READY, VECTOR_REQ, K_EN, E_EN, V_EN, WK_START, EV_START, WV_START} !== 9'd0 ||
            (WK_SIZE | AG_GA | VECTOR_INDEX) !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got busy=%b ready=%b req=%b want 0",
                     BUSY, READY, VECTOR_REQ);
        end
        RST = 1'b0;
        clear_obs();
        repeat (20) begin @(posedge CLK); #1; observe(); end
        n_vec++;
        if (ready_cnt != 0 || BUSY !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_no_ready: got %0d want 0", ready_cnt);
        end
        exp_n = 2;
        start_job(64'd2, 64'd4, 64'd4, 64'd4);
        run_to_ready(500, 0, lat);
        n_vec++;
        if (lat != 22) begin
            n_bad++; $display("FAIL rst_mid_rerun: got %0d want 22", lat);
        end
        check_stream("rerun", 2);
    endtask

    initial begin
        test_reset();
        test_scalar_only();
        test_normal();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
